// File: rtl/reg_alu_pipe.sv
// Two-stage register-file ALU pipeline: S1 operand capture, S2 registered result with writeback.
// Define REG_ALU_PIPE_FWD_EN to bypass the S1 ALU output on read-after-write hazards instead of stalling.
module reg_alu_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned EXT_W = DATA_W + 1;

  logic [DATA_W-1:0] rf [DEPTH];

  logic              s1_valid;
  logic [2:0]        s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [ADDR_W-1:0] s1_wr_addr;
  logic              s1_wr_en;

  logic [EXT_W-1:0]  add_ext;
  logic [EXT_W-1:0]  sub_ext;
  logic [EXT_W-1:0]  inc_ext;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic              s1_writes;
  logic              haz_a;
  logic              haz_b;
  logic              hazard;
  logic              op_fire;
  logic              ld_fire;
  logic              wb_fire;

  // ALU on the S1 operands
  assign add_ext = {1'b0, s1_a} + {1'b0, s1_b};
  assign sub_ext = {1'b0, s1_a} - {1'b0, s1_b};
  assign inc_ext = {1'b0, s1_a} + EXT_W'(1);

  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (s1_op)
      3'b000: alu_out = s1_a;
      3'b001: begin
        alu_out   = add_ext[DATA_W-1:0];
        alu_carry = add_ext[DATA_W];
      end
      3'b010: begin
        alu_out   = sub_ext[DATA_W-1:0];
        alu_carry = ~sub_ext[DATA_W];
      end
      3'b011: alu_out = s1_a & s1_b;
      3'b100: alu_out = s1_a | s1_b;
      3'b101: alu_out = s1_a ^ s1_b;
      3'b110: alu_out = ~s1_a;
      3'b111: begin
        alu_out   = inc_ext[DATA_W-1:0];
        alu_carry = inc_ext[DATA_W];
      end
      default: alu_out = '0;
    endcase
  end

  // Register reads see pre-edge contents, so a same-cycle load is not visible to the op
  assign rd_a = (ra_addr == '0) ? '0 : rf[ra_addr];
  assign rd_b = (rb_addr == '0) ? '0 : rf[rb_addr];

  assign s1_writes = s1_valid && s1_wr_en && (s1_wr_addr != '0);
  assign haz_a     = s1_writes && (ra_addr == s1_wr_addr);
  assign haz_b     = s1_writes && (rb_addr == s1_wr_addr);
  assign hazard    = haz_a || haz_b;

`ifdef REG_ALU_PIPE_FWD_EN
  assign opnd_a   = haz_a ? alu_out : rd_a;
  assign opnd_b   = haz_b ? alu_out : rd_b;
  assign op_ready = !reset;
`else
  assign opnd_a   = rd_a;
  assign opnd_b   = rd_b;
  assign op_ready = !reset && !hazard;
`endif

  // Loads wait while S1 holds a pending writeback, so the two never share an edge
  assign ld_ready = !reset && (!s1_valid || !s1_wr_en);
  assign op_fire  = op_valid && op_ready;
  assign ld_fire  = ld_valid && ld_ready;
  assign wb_fire  = s1_writes;

  // S1 operand stage and S2 result stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_wr_addr <= '0;
      s1_wr_en   <= 1'b0;
      res_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      carry      <= 1'b0;
    end else begin
      s1_valid <= op_fire;
      if (op_fire) begin
        s1_op      <= op_code;
        s1_a       <= opnd_a;
        s1_b       <= opnd_b;
        s1_wr_addr <= wr_addr;
        s1_wr_en   <= wr_en;
      end
      res_valid <= s1_valid;
      if (s1_valid) begin
        result <= alu_out;
        zero   <= (alu_out == '0);
        carry  <= alu_carry;
      end
    end
  end

  // Register file; entry 0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (wb_fire) begin
        rf[s1_wr_addr] <= alu_out;
      end
      if (ld_fire && (ld_addr != '0)) begin
        rf[ld_addr] <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed self-checking bench for reg_alu_pipe; expected timing follows REG_ALU_PIPE_FWD_EN when defined.
module tb_reg_alu_pipe;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              res_valid;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              carry;

  int n_pass  = 0;
  int n_total = 0;

  reg_alu_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .wr_addr  (wr_addr),
    .wr_en    (wr_en),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .res_valid(res_valid),
    .result   (result),
    .zero     (zero),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] code, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] wr, input logic we);
    op_valid = 1'b1;
    op_code  = code;
    ra_addr  = ra;
    rb_addr  = rb;
    wr_addr  = wr;
    wr_en    = we;
  endtask

  task automatic do_load(input logic [4:0] a, input logic [15:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [15:0] v);
    set_op(3'b000, a, 5'd0, 5'd0, 1'b0);
    tick();
    op_valid = 1'b0;
    tick();
    v = result;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_total++; if (op_ready !== 1'b0) $display("FAIL rst_op_ready: got %0b want 0", op_ready); else n_pass++;
    n_total++; if (ld_ready !== 1'b0) $display("FAIL rst_ld_ready: got %0b want 0", ld_ready); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %0b want 0", res_valid); else n_pass++;
    n_total++; if (result !== 16'h0000) $display("FAIL rst_result: got %h want 0000", result); else n_pass++;
    n_total++; if (zero !== 1'b0 || carry !== 1'b0) $display("FAIL rst_flags: got z=%0b c=%0b want 0 0", zero, carry); else n_pass++;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_total++; if (op_ready !== 1'b1) $display("FAIL post_rst_op_ready: got %0b want 1", op_ready); else n_pass++;
    n_total++; if (ld_ready !== 1'b1) $display("FAIL post_rst_ld_ready: got %0b want 1", ld_ready); else n_pass++;
  endtask

  task automatic test_add();
    logic [15:0] v;
    do_load(5'd1, 16'h0005);
    do_load(5'd2, 16'h0003);
    set_op(3'b001, 5'd1, 5'd2, 5'd3, 1'b1);
    tick();
    op_valid = 1'b0;
    n_total++; if (res_valid !== 1'b0) $display("FAIL add_latency: res_valid got %0b want 0", res_valid); else n_pass++;
    tick();
    n_total++; if (res_valid !== 1'b1) $display("FAIL add_valid: got %0b want 1", res_valid); else n_pass++;
    n_total++; if (result !== 16'h0008) $display("FAIL add_result: got %h want 0008", result); else n_pass++;
    n_total++; if (zero !== 1'b0 || carry !== 1'b0) $display("FAIL add_flags: got z=%0b c=%0b want 0 0", zero, carry); else n_pass++;
    tick();
    n_total++; if (res_valid !== 1'b0) $display("FAIL add_valid_drop: got %0b want 0", res_valid); else n_pass++;
    n_total++; if (result !== 16'h0008) $display("FAIL add_hold: got %h want 0008", result); else n_pass++;
    read_reg(5'd3, v);
    n_total++; if (v !== 16'h0008) $display("FAIL add_r3: got %h want 0008", v); else n_pass++;
  endtask

  task automatic test_carry();
    logic [2:0]  codes [4] = '{3'b001, 3'b010, 3'b010, 3'b111};
    logic [4:0]  ras   [4] = '{5'd1, 5'd2, 5'd1, 5'd1};
    logic [4:0]  rbs   [4] = '{5'd2, 5'd1, 5'd2, 5'd0};
    logic [15:0] exps  [4] = '{16'h0000, 16'h0002, 16'hFFFE, 16'h0000};
    logic        expc  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        expz  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_load(5'd1, 16'hFFFF);
    do_load(5'd2, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      set_op(codes[i], ras[i], rbs[i], 5'd4, 1'b0);
      tick();
      op_valid = 1'b0;
      tick();
      n_total++; if (result !== exps[i]) $display("FAIL arith_result[%0d]: got %h want %h", i, result, exps[i]); else n_pass++;
      n_total++; if (carry !== expc[i]) $display("FAIL arith_carry[%0d]: got %0b want %0b", i, carry, expc[i]); else n_pass++;
      n_total++; if (zero !== expz[i]) $display("FAIL arith_zero[%0d]: got %0b want %0b", i, zero, expz[i]); else n_pass++;
    end
  endtask

  task automatic test_logic();
    logic [2:0]  codes [4] = '{3'b011, 3'b100, 3'b101, 3'b110};
    logic [15:0] exps  [4] = '{16'h3030, 16'hFCFC, 16'hCCCC, 16'h0F0F};
    do_load(5'd5, 16'hF0F0);
    do_load(5'd6, 16'h3C3C);
    for (int i = 0; i < 4; i++) begin
      set_op(codes[i], 5'd5, 5'd6, 5'd0, 1'b0);
      tick();
      op_valid = 1'b0;
      tick();
      n_total++; if (result !== exps[i]) $display("FAIL logic_result[%0d]: got %h want %h", i, result, exps[i]); else n_pass++;
      n_total++; if (carry !== 1'b0) $display("FAIL logic_carry[%0d]: got %0b want 0", i, carry); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  codes [3] = '{3'b001, 3'b010, 3'b101};
    logic [15:0] exps  [3] = '{16'h0008, 16'h0002, 16'h0006};
    logic [15:0] v;
    do_load(5'd1, 16'h0005);
    do_load(5'd2, 16'h0003);
    // independent ops stream one per cycle
    for (int i = 0; i < 3; i++) begin
      set_op(codes[i], 5'd1, 5'd2, 5'd0, 1'b0);
      #1;
      n_total++; if (op_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %0b want 1", i, op_ready); else n_pass++;
      tick();
      if (i >= 1) begin
        n_total++; if (res_valid !== 1'b1 || result !== exps[i-1]) $display("FAIL b2b_result[%0d]: got v=%0b %h want v=1 %h", i-1, res_valid, result, exps[i-1]); else n_pass++;
      end
    end
    op_valid = 1'b0;
    tick();
    n_total++; if (res_valid !== 1'b1 || result !== exps[2]) $display("FAIL b2b_result[2]: got v=%0b %h want v=1 %h", res_valid, result, exps[2]); else n_pass++;
    // dependent pair: r3 = r1 + r2, then r7 = r3 + r2
    set_op(3'b001, 5'd1, 5'd2, 5'd3, 1'b1);
    tick();
    set_op(3'b001, 5'd3, 5'd2, 5'd7, 1'b1);
    #1;
`ifdef REG_ALU_PIPE_FWD_EN
    n_total++; if (op_ready !== 1'b1) $display("FAIL haz_ready: got %0b want 1", op_ready); else n_pass++;
    tick();
    op_valid = 1'b0;
    n_total++; if (result !== 16'h0008) $display("FAIL haz_first: got %h want 0008", result); else n_pass++;
    tick();
    n_total++; if (res_valid !== 1'b1 || result !== 16'h000B) $display("FAIL haz_second: got v=%0b %h want v=1 000b", res_valid, result); else n_pass++;
`else
    n_total++; if (op_ready !== 1'b0) $display("FAIL haz_stall: got %0b want 0", op_ready); else n_pass++;
    tick();
    n_total++; if (result !== 16'h0008) $display("FAIL haz_first: got %h want 0008", result); else n_pass++;
    n_total++; if (op_ready !== 1'b1) $display("FAIL haz_release: got %0b want 1", op_ready); else n_pass++;
    tick();
    op_valid = 1'b0;
    n_total++; if (res_valid !== 1'b0) $display("FAIL haz_bubble: got %0b want 0", res_valid); else n_pass++;
    tick();
    n_total++; if (res_valid !== 1'b1 || result !== 16'h000B) $display("FAIL haz_second: got v=%0b %h want v=1 000b", res_valid, result); else n_pass++;
`endif
    tick();
    read_reg(5'd7, v);
    n_total++; if (v !== 16'h000B) $display("FAIL haz_r7: got %h want 000b", v); else n_pass++;
  endtask

  task automatic test_r0();
    logic [15:0] v;
    do_load(5'd1, 16'h1234);
    set_op(3'b000, 5'd1, 5'd0, 5'd0, 1'b1);
    tick();
    op_valid = 1'b0;
    tick();
    n_total++; if (result !== 16'h1234) $display("FAIL r0_pass: got %h want 1234", result); else n_pass++;
    read_reg(5'd0, v);
    n_total++; if (v !== 16'h0000) $display("FAIL r0_wb: got %h want 0000", v); else n_pass++;
    do_load(5'd0, 16'hBEEF);
    read_reg(5'd0, v);
    n_total++; if (v !== 16'h0000) $display("FAIL r0_load: got %h want 0000", v); else n_pass++;
  endtask

  task automatic test_load_same_cycle();
    logic [15:0] v;
    do_load(5'd4, 16'h0011);
    set_op(3'b000, 5'd4, 5'd0, 5'd0, 1'b0);
    ld_valid = 1'b1;
    ld_addr  = 5'd4;
    ld_data  = 16'h0022;
    tick();
    op_valid = 1'b0;
    ld_valid = 1'b0;
    tick();
    n_total++; if (result !== 16'h0011) $display("FAIL ld_pre_value: got %h want 0011", result); else n_pass++;
    read_reg(5'd4, v);
    n_total++; if (v !== 16'h0022) $display("FAIL ld_post_value: got %h want 0022", v); else n_pass++;
  endtask

  task automatic test_ld_block();
    logic [15:0] v;
    do_load(5'd1, 16'h1234);
    do_load(5'd2, 16'h0003);
    set_op(3'b001, 5'd1, 5'd2, 5'd5, 1'b1);
    tick();
    op_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 5'd6;
    ld_data  = 16'h0ABC;
    #1;
    n_total++; if (ld_ready !== 1'b0) $display("FAIL ld_blocked: got %0b want 0", ld_ready); else n_pass++;
    tick();
    n_total++; if (ld_ready !== 1'b1) $display("FAIL ld_unblocked: got %0b want 1", ld_ready); else n_pass++;
    tick();
    ld_valid = 1'b0;
    read_reg(5'd6, v);
    n_total++; if (v !== 16'h0ABC) $display("FAIL ld_r6: got %h want 0abc", v); else n_pass++;
    read_reg(5'd5, v);
    n_total++; if (v !== 16'h1237) $display("FAIL ld_r5: got %h want 1237", v); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    do_load(5'd1, 16'h0055);
    set_op(3'b000, 5'd1, 5'd0, 5'd9, 1'b1);
    tick();
    set_op(3'b000, 5'd1, 5'd0, 5'd8, 1'b1);
    tick();
    op_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_total++; if (res_valid !== 1'b0) $display("FAIL mid_res_valid: got %0b want 0", res_valid); else n_pass++;
    n_total++; if (result !== 16'h0000) $display("FAIL mid_result: got %h want 0000", result); else n_pass++;
    n_total++; if (op_ready !== 1'b0 || ld_ready !== 1'b0) $display("FAIL mid_ready: got op=%0b ld=%0b want 0 0", op_ready, ld_ready); else n_pass++;
    tick();
    reset = 1'b0;
    #1;
    read_reg(5'd8, v);
    n_total++; if (v !== 16'h0000) $display("FAIL mid_r8: got %h want 0000", v); else n_pass++;
    read_reg(5'd9, v);
    n_total++; if (v !== 16'h0000) $display("FAIL mid_r9: got %h want 0000", v); else n_pass++;
    read_reg(5'd1, v);
    n_total++; if (v !== 16'h0000) $display("FAIL mid_r1: got %h want 0000", v); else n_pass++;
  endtask

  initial begin
    reset    = 1'b0;
    op_valid = 1'b0;
    op_code  = '0;
    ra_addr  = '0;
    rb_addr  = '0;
    wr_addr  = '0;
    wr_en    = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    #1;
    test_reset();
    test_add();
    test_carry();
    test_logic();
    test_back_to_back();
    test_r0();
    test_load_same_cycle();
    test_ld_block();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
